cpu_display_scanner: RTL
========================

// Module: cpu_display_scanner
// PURPOSE
//  Reader on the CPU debug-display interface. On request it walks the CPU's display ports and
//  emits one coherent dump as a record stream with a valid/ready handshake for the LCD/UART
//  driver. A dump is status words, then registers r0..r31, then MEM_WORDS data-memory words.
//  The scanner drives rf_addr/mem_addr and samples rf_data (combinational) and mem_data
//  (synchronous RAM port, 1-cycle read latency).
// PARAMETERS
//  MEM_WORDS    16  number of data-memory words per dump; legal range 1..256
//  AUTO_PERIOD  0   IDLE cycles before a self-started dump; 0 = start pin only
// PORTS
//  clk          in   1   single clock; all state on its rising edge
//  resetn       in   1   asynchronous, active-low reset
//  start        in   1   one-cycle request for a dump; ignored while busy
//  mem_base     in   32  first memory byte address; latched at start; [1:0] forced to 0
//  rf_addr      out  5   register index presented to regfile test port
//  rf_data      in   32  regfile test data, valid in the same cycle as rf_addr
//  mem_addr     out  32  byte address presented to data_ram port B
//  mem_data     in   32  data_ram port B data, valid the cycle after mem_addr
//  IF_pc,IF_inst,ID_pc,EXE_pc,MEM_pc,WB_pc,cpu_5_valid,HI_data,LO_data  in  32 each  status
//  out_valid    out  1   record available
//  out_ready    in   1   downstream accepts the record when out_valid & out_ready
//  out_tag      out  10  [9:8] class (0 status, 1 reg, 2 mem, 3 cksum), [7:0] index
//  out_data     out  32  record payload
//  busy         out  1   high from start acceptance until the final record transfers
//  done         out  1   one-cycle pulse the cycle after the final transfer
// BEHAVIOUR
//  - Reset values: out_valid, busy, done = 0; out_tag, out_data, rf_addr, mem_addr = 0;
//    FSM = IDLE; auto counter = 0.
//  - FSM states: IDLE -> STAT -> REG -> MADDR -> MWAIT -> MOUT -> (MADDR | FIN) -> IDLE.
//  - IDLE: start=1 at edge N latches mem_base, snapshots all 9 status inputs into one coherent
//    copy, loads record 0, and sets busy. out_valid is high from cycle N+1.
//  - STAT: emits status indices 0..8 in port-list order (IF_pc .. LO_data), one per transfer.
//  - REG: rf_addr = index; on each transfer the next record loads rf_data of the next index.
//    Index 0..31.
//  - MADDR: drives mem_addr = base + 4*i, modulo 2^32 with wrap allowed.
//  - MWAIT: one cycle. At the next edge mem_data is captured into out_data, and MOUT raises
//    out_valid. After the transfer, either i+1 goes to MADDR, or i = MEM_WORDS-1 goes to FIN.
//    Each mem record costs at least 3 cycles.
//  - Handshake: out_tag/out_data are stable while out_valid & ~out_ready; no record is dropped
//    or duplicated. A stall of any length is legal. A new record loads at the transfer edge;
//    there is no bubble in STAT/REG.
//  - FIN: busy drops and done pulses. The counter resets in IDLE.
//  - Record count = 9 + 32 + MEM_WORDS (+1 with SCAN_CKSUM_EN).
//  - start while busy is ignored; start coinciding with an auto trigger gives one dump.
//  - Auto mode: the counter increments each IDLE cycle; reaching AUTO_PERIOD starts a dump
//    as if start with mem_base.
//  - resetn low at any time, including mid-dump: all outputs return to reset values at once
//    and the partial dump is abandoned. There is no resume.
// CONFIGURATION
//  SCAN_CKSUM_EN defined: after the last mem record, one extra record is emitted:
//    class 3, index 0, data = XOR of every out_data in this dump.
//  SCAN_CKSUM_EN undefined: no checksum record and no accumulator logic; the dump ends at the
//    last mem record.
// STRUCTURE
//  - Package cpu_disp_pkg: class codes (CLS_STAT/REG/MEM/CKSUM), NUM_STATUS=9, NUM_REGS=32,
//    tag-field widths, FSM state encoding.
//  - One sub-module, disp_rec_reg: output holding register with valid/ready, load strobe and
//    async clear.
//  - FSM, index counters, snapshot and auto timer live in the top.
// TESTING
//  1. Reset, then start, MEM_WORDS=4, base=0x40, out_ready=1 -> 45 records in order:
//     tags 0x000..0x008, 0x100..0x11F, 0x200..0x203. mem_addr takes 0x40,0x44,0x48,0x4C.
//     done 1 cycle after the last transfer.
//  2. Status inputs change every cycle during a dump -> all 9 status records equal the values
//     at the start edge.
//  3. out_ready toggles 1-0-0-1 randomly -> the stream is identical to test 1, and tag/data
//     never change while stalled.
//  4. base=0xFFFFFFF8, MEM_WORDS=4 -> mem_addr sequence FFFFFFF8, FFFFFFFC, 00000000,
//     00000004.
//  5. resetn pulsed low at record 20 -> out_valid=0 and busy=0 immediately; a later start
//     gives a full fresh dump from tag 0x000.
//  6. SCAN_CKSUM_EN, regs preloaded r_i=i, other data 0 -> the final record has tag 0x300 and
//     data = XOR(0..31) = 0x00000000; with AUTO_PERIOD=10 the next dump starts 10 IDLE
//     cycles after done.

Source files
------------

// File: rtl/cpu_disp_pkg.sv
// Shared definitions for the CPU debug-display scanner.
//   - record class codes carried in out_tag[9:8]
//   - number of status words and registers per dump
//   - tag field widths
//   - scanner FSM state encoding
package cpu_disp_pkg;

    localparam int NUM_STATUS = 9;
    localparam int NUM_REGS   = 32;
    localparam int TAG_CLS_W  = 2;
    localparam int TAG_IDX_W  = 8;
    localparam int TAG_W      = TAG_CLS_W + TAG_IDX_W;

    localparam logic [TAG_CLS_W-1:0] CLS_STAT  = 2'd0;
    localparam logic [TAG_CLS_W-1:0] CLS_REG   = 2'd1;
    localparam logic [TAG_CLS_W-1:0] CLS_MEM   = 2'd2;
    localparam logic [TAG_CLS_W-1:0] CLS_CKSUM = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STAT,
        ST_REG,
        ST_MADDR,
        ST_MWAIT,
        ST_MOUT,
        ST_CKSUM,
        ST_FIN
    } scan_state_e;

    function automatic logic [TAG_W-1:0] make_tag(input logic [TAG_CLS_W-1:0] cls,
                                                  input logic [TAG_IDX_W-1:0] idx);
        return {cls, idx};
    endfunction

endpackage

// File: rtl/disp_rec_reg.sv
// Output holding register for the scanner record stream.
// Ports:
//   clk, resetn        clock, asynchronous active-low clear
//   load               capture load_tag/load_data and raise valid
//   load_tag/load_data next record contents
//   ready              downstream accept
//   valid, tag, data   registered record presented downstream
// Handshake: a record transfers on an edge where valid & ready. While valid is
// high and ready low, tag/data hold. A load on the transfer edge replaces the
// record without a bubble; otherwise valid drops after the transfer.
module disp_rec_reg
    import cpu_disp_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [TAG_W-1:0] load_tag,
    input  logic [31:0]      load_data,
    input  logic             ready,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [31:0]      data
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= load_tag;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_display_scanner.sv
// CPU debug-display scanner: on start (or auto timer) emits one coherent dump
// of 9 status words, registers r0..r31 and MEM_WORDS data-memory words as a
// valid/ready record stream.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start, mem_base        dump request and first memory byte address
//   rf_addr / rf_data      regfile test port (combinational read)
//   mem_addr / mem_data    data RAM port B (one-cycle read latency)
//   IF_pc .. LO_data       status inputs, snapshotted at the start edge
//   out_valid/out_ready    record handshake; out_tag = {class, index}, out_data
//   busy, done             dump in progress / one-cycle completion pulse
// Optional feature: define SCAN_CKSUM_EN to append an XOR checksum record.
module cpu_display_scanner
    import cpu_disp_pkg::*;
#(
    parameter int MEM_WORDS   = 16,
    parameter int AUTO_PERIOD = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      mem_base,
    output logic [4:0]       rf_addr,
    input  logic [31:0]      rf_data,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_data,
    input  logic [31:0]      IF_pc,
    input  logic [31:0]      IF_inst,
    input  logic [31:0]      ID_pc,
    input  logic [31:0]      EXE_pc,
    input  logic [31:0]      MEM_pc,
    input  logic [31:0]      WB_pc,
    input  logic [31:0]      cpu_5_valid,
    input  logic [31:0]      HI_data,
    input  logic [31:0]      LO_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done
);

    scan_state_e          state, state_n;
    logic [7:0]           idx, idx_n, idx_inc;
    logic [31:0]          base;
    logic [31:0]          snap [NUM_STATUS];
    logic [31:0]          cnt;
    logic                 auto_hit, trig, xfer;
    logic                 load;
    logic [TAG_W-1:0]     load_tag;
    logic [31:0]          load_data;
`ifdef SCAN_CKSUM_EN
    logic [31:0]          acc;
`endif

    assign xfer     = out_valid & out_ready;
    assign idx_inc  = idx + 8'd1;
    assign auto_hit = (AUTO_PERIOD != 0) && (state == ST_IDLE) && (cnt == 32'(AUTO_PERIOD - 1));
    assign trig     = start | auto_hit;

    // rf_addr points at the register that the next transfer will load, so the
    // combinational rf_data is ready on the transfer edge.
    assign rf_addr  = (state == ST_REG) ? idx_inc[4:0] : 5'd0;
    assign mem_addr = (state == ST_MADDR || state == ST_MWAIT) ? base + {22'd0, idx, 2'b00} : 32'd0;
    assign busy     = (state != ST_IDLE) && (state != ST_FIN);
    assign done     = (state == ST_FIN);

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        load      = 1'b0;
        load_tag  = '0;
        load_data = '0;
        case (state)
            ST_IDLE: if (trig) begin
                state_n   = ST_STAT;
                idx_n     = 8'd0;
                load      = 1'b1;
                load_tag  = make_tag(CLS_STAT, 8'd0);
                load_data = IF_pc;
            end
            ST_STAT: if (xfer) begin
                load = 1'b1;
                if (idx == 8'(NUM_STATUS - 1)) begin
                    state_n   = ST_REG;
                    idx_n     = 8'd0;
                    load_tag  = make_tag(CLS_REG, 8'd0);
                    load_data = rf_data;
                end else begin
                    idx_n     = idx_inc;
                    load_tag  = make_tag(CLS_STAT, idx_inc);
                    load_data = snap[idx_inc[3:0]];
                end
            end
            ST_REG: if (xfer) begin
                if (idx == 8'(NUM_REGS - 1)) begin
                    state_n = ST_MADDR;
                    idx_n   = 8'd0;
                end else begin
                    idx_n     = idx_inc;
                    load      = 1'b1;
                    load_tag  = make_tag(CLS_REG, idx_inc);
                    load_data = rf_data;
                end
            end
            ST_MADDR: state_n = ST_MWAIT;
            ST_MWAIT: begin
                state_n   = ST_MOUT;
                load      = 1'b1;
                load_tag  = make_tag(CLS_MEM, idx);
                load_data = mem_data;
            end
            ST_MOUT: if (xfer) begin
                if (idx == 8'(MEM_WORDS - 1)) begin
`ifdef SCAN_CKSUM_EN
                    state_n   = ST_CKSUM;
                    load      = 1'b1;
                    load_tag  = make_tag(CLS_CKSUM, 8'd0);
                    load_data = acc;
`else
                    state_n   = ST_FIN;
`endif
                end else begin
                    idx_n   = idx_inc;
                    state_n = ST_MADDR;
                end
            end
            ST_CKSUM: if (xfer) state_n = ST_FIN;
            ST_FIN:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            idx   <= '0;
            base  <= '0;
            cnt   <= '0;
            for (int i = 0; i < NUM_STATUS; i++) snap[i] <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            // Auto timer only runs while idle and is cleared by any dump start.
            if (state != ST_IDLE || trig) cnt <= '0;
            else if (AUTO_PERIOD != 0)    cnt <= cnt + 32'd1;
            if (state == ST_IDLE && trig) begin
                base    <= mem_base & 32'hFFFF_FFFC;
                snap[0] <= IF_pc;
                snap[1] <= IF_inst;
                snap[2] <= ID_pc;
                snap[3] <= EXE_pc;
                snap[4] <= MEM_pc;
                snap[5] <= WB_pc;
                snap[6] <= cpu_5_valid;
                snap[7] <= HI_data;
                snap[8] <= LO_data;
            end
        end
    end

`ifdef SCAN_CKSUM_EN
    // Folds every loaded record; restarts with the first record of a dump.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    acc <= '0;
        else if (load)  acc <= ((state == ST_IDLE) ? 32'd0 : acc) ^ load_data;
    end
`endif

    disp_rec_reg u_rec (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .load_tag  (load_tag),
        .load_data (load_data),
        .ready     (out_ready),
        .valid     (out_valid),
        .tag       (out_tag),
        .data      (out_data)
    );

endmodule
